// File: rtl/node_io_pkg.sv
// Shared definitions for the node I/O port: arbiter command encodings and
// message field helpers. Message layout is {dst, src, payload}, dst in the MSBs.
package node_io_pkg;

   localparam int MSG_MAX_W  = 64;
   localparam int ADDR_MAX_W = 8;

   typedef enum logic [2:0] {
      CTRL_IDLE = 3'b000,
      CTRL_BYP  = 3'b001,
      CTRL_RX   = 3'b010,
      CTRL_TX   = 3'b100
   } ctrl_e;

   function automatic logic [ADDR_MAX_W-1:0] addr_mask(input int addr_w);
      logic [ADDR_MAX_W-1:0] one;
      one = {{(ADDR_MAX_W-1){1'b0}}, 1'b1};
      return (one << addr_w) - one;
   endfunction

   // Callers zero-extend the message to MSG_MAX_W and pass the real widths.
   function automatic logic [ADDR_MAX_W-1:0] msg_dst(input logic [MSG_MAX_W-1:0] msg,
                                                      input int msg_w, input int addr_w);
      logic [MSG_MAX_W-1:0] sh;
      sh = msg >> (msg_w - addr_w);
      return sh[ADDR_MAX_W-1:0] & addr_mask(addr_w);
   endfunction

   function automatic logic [ADDR_MAX_W-1:0] msg_src(input logic [MSG_MAX_W-1:0] msg,
                                                      input int msg_w, input int addr_w);
      logic [MSG_MAX_W-1:0] sh;
      sh = msg >> (msg_w - 2*addr_w);
      return sh[ADDR_MAX_W-1:0] & addr_mask(addr_w);
   endfunction

   function automatic logic dir_ok(input logic [ADDR_MAX_W-1:0] dst,
                                   input logic [ADDR_MAX_W-1:0] node_id,
                                   input logic dir);
      logic ok;
      if (dir) begin
         ok = (dst < node_id);
      end else begin
         ok = (dst > node_id);
      end
      return ok;
   endfunction

endpackage

// File: rtl/node_io_fifo.sv
// Circular queue with two write ports and one read port per cycle.
// Port 1 lands after port 0 when both write, so port 0 is the older entry.
module node_io_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr0_en,
   input  logic [W-1:0]               wr0_data,
   input  logic                       wr1_en,
   input  logic [W-1:0]               wr1_data,
   input  logic                       rd_en,
   output logic [W-1:0]               rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [W-1:0]     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [PTR_W-1:0] wr_inc1_s, wr_inc2_s, wr1_slot_s, wr_ptr_next_s, rd_ptr_next_s;
   logic [CNT_W-1:0] count_next_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] n;
      if (p == PTR_W'(DEPTH-1)) begin
         n = '0;
      end else begin
         n = p + PTR_W'(1);
      end
      return n;
   endfunction

   // Next-pointer and occupancy arithmetic.
   always_comb begin
      wr_inc1_s = ptr_inc(wr_ptr_r);
      wr_inc2_s = ptr_inc(wr_inc1_s);
      if (wr0_en) begin
         wr1_slot_s = wr_inc1_s;
      end else begin
         wr1_slot_s = wr_ptr_r;
      end
      if (wr0_en && wr1_en) begin
         wr_ptr_next_s = wr_inc2_s;
      end else if (wr0_en || wr1_en) begin
         wr_ptr_next_s = wr_inc1_s;
      end else begin
         wr_ptr_next_s = wr_ptr_r;
      end
      if (rd_en) begin
         rd_ptr_next_s = ptr_inc(rd_ptr_r);
      end else begin
         rd_ptr_next_s = rd_ptr_r;
      end
      count_next_s = count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
   end

   // Storage is not reset; validity comes from pointers and count only.
   always_ff @(posedge clk) begin
      if (wr0_en) begin
         mem_r[wr_ptr_r] <= wr0_data;
      end
      if (wr1_en) begin
         mem_r[wr1_slot_s] <= wr1_data;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count    <= '0;
      end else begin
         wr_ptr_r <= wr_ptr_next_s;
         rd_ptr_r <= rd_ptr_next_s;
         count    <= count_next_s;
      end
   end

   assign rd_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/node_port_fifo.sv
// Node port on the interposer bus: delivers local traffic, queues forwards and
// correct-direction injections, and requests the bus for the queue head.
module node_port_fifo
   import node_io_pkg::*;
#(
   parameter int NODE_ID    = 0,
   parameter int NODE_COUNT = 8,
   parameter int ADDR_W     = $clog2(NODE_COUNT),
   parameter int PAYLOAD_W  = 16,
   parameter int DEPTH      = 8,
   parameter int DIR        = 0,
   parameter int MSG_W      = PAYLOAD_W + 2*ADDR_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [MSG_W-1:0]           bus_in,
   input  logic [2:0]                 ctrl,
   input  logic                       inj_valid,
   input  logic [MSG_W-1:0]           inj_msg,
   output logic                       inj_ready,
   output logic [MSG_W-1:0]           bus_out,
   output logic                       bus_out_valid,
   output logic                       req_valid,
   output logic [ADDR_W-1:0]          req_dst,
   output logic                       rx_valid,
   output logic [MSG_W-ADDR_W-1:0]    rx_msg,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       ctrl_err,
   output logic                       dir_err,
   output logic [7:0]                 drop_cnt
);

   localparam int                    CNT_W     = $clog2(DEPTH+1);
   localparam int                    RX_W      = MSG_W - ADDR_W;
   localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]      INJ_LIMIT = CNT_W'(DEPTH-2);
   localparam logic [ADDR_W-1:0]     NODE_ADDR = ADDR_W'(NODE_ID);
   localparam logic [ADDR_MAX_W-1:0] NODE_X    = ADDR_MAX_W'(NODE_ID);
   localparam logic                  DIR_B     = (DIR != 0);

   logic [ADDR_W-1:0] bus_dst_s, inj_dst_s, head_dst_s, head_dst_next_s;
   logic [MSG_W-1:0]  head_msg_s, wr0_data_s;
   logic [CNT_W-1:0]  count_next_s;
   logic is_tx_s, is_rx_s, is_byp_s, bad_ctrl_s;
   logic pop_s, rx_local_s, fwd_s, fwd_push_s, drop_s;
   logic inj_fire_s, inj_dir_ok_s, inj_push_s, inj_bad_s;

   assign bus_dst_s    = ADDR_W'(msg_dst(MSG_MAX_W'(bus_in), MSG_W, ADDR_W));
   assign inj_dst_s    = ADDR_W'(msg_dst(MSG_MAX_W'(inj_msg), MSG_W, ADDR_W));
   assign head_dst_s   = ADDR_W'(msg_dst(MSG_MAX_W'(head_msg_s), MSG_W, ADDR_W));
   assign inj_dir_ok_s = dir_ok(ADDR_MAX_W'(inj_dst_s), NODE_X, DIR_B);
   assign wr0_data_s   = fwd_push_s ? bus_in : inj_msg;

   node_io_fifo #(
      .W     (MSG_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr0_en   (fwd_push_s | inj_push_s),
      .wr0_data (wr0_data_s),
      .wr1_en   (fwd_push_s & inj_push_s),
      .wr1_data (inj_msg),
      .rd_en    (pop_s),
      .rd_data  (head_msg_s),
      .count    (count)
   );

   // Command decode and queue push/pop decisions.
   always_comb begin
      is_tx_s    = 1'b0;
      is_rx_s    = 1'b0;
      is_byp_s   = 1'b0;
      bad_ctrl_s = 1'b0;
      case (ctrl)
         CTRL_TX:   is_tx_s    = 1'b1;
         CTRL_RX:   is_rx_s    = 1'b1;
         CTRL_BYP:  is_byp_s   = 1'b1;
         CTRL_IDLE: bad_ctrl_s = 1'b0;
         default:   bad_ctrl_s = 1'b1;
      endcase
      pop_s      = is_tx_s && (count != '0);
      rx_local_s = is_rx_s && (bus_dst_s == NODE_ADDR);
      fwd_s      = is_rx_s && !rx_local_s;
      // A forward never shares a cycle with a pop, so full means count == DEPTH.
      fwd_push_s = fwd_s && (count < DEPTH_C);
      drop_s     = fwd_s && !fwd_push_s;
      inj_fire_s = inj_valid && inj_ready;
      inj_push_s = inj_fire_s && inj_dir_ok_s;
      inj_bad_s  = inj_fire_s && !inj_dir_ok_s;
      count_next_s = count + CNT_W'(fwd_push_s) + CNT_W'(inj_push_s) - CNT_W'(pop_s);
      if (count != '0) begin
         head_dst_next_s = head_dst_s;
      end else if (fwd_push_s) begin
         head_dst_next_s = bus_dst_s;
      end else begin
         head_dst_next_s = inj_dst_s;
      end
   end

   // Registered outputs; req_valid doubles as the request-pending flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         inj_ready     <= 1'b1;
         bus_out       <= '0;
         bus_out_valid <= 1'b0;
         req_valid     <= 1'b0;
         req_dst       <= '0;
         rx_valid      <= 1'b0;
         rx_msg        <= '0;
         ctrl_err      <= 1'b0;
         dir_err       <= 1'b0;
         drop_cnt      <= 8'd0;
      end else begin
         inj_ready <= (count_next_s <= INJ_LIMIT);
         rx_valid  <= rx_local_s;
         if (rx_local_s) begin
            rx_msg <= bus_in[RX_W-1:0];
         end
         ctrl_err <= bad_ctrl_s | (is_tx_s & ~pop_s);
         dir_err  <= inj_bad_s;
         if (drop_s && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
         if (pop_s) begin
            bus_out       <= head_msg_s;
            bus_out_valid <= 1'b1;
         end else if (is_byp_s) begin
            bus_out       <= bus_in;
            bus_out_valid <= 1'b1;
         end else begin
            bus_out_valid <= 1'b0;
         end
         if (pop_s) begin
            req_valid <= 1'b0;
         end else if (!req_valid && (count_next_s != '0)) begin
            req_valid <= 1'b1;
            req_dst   <= head_dst_next_s;
         end
      end
   end

endmodule

// File: tb/tb_node_port_fifo.sv
// Scoreboard bench for node_port_fifo (NODE_ID=3, DIR=0, DEPTH=4, PAYLOAD_W=16).
module tb_node_port_fifo;

   localparam int NODE_ID   = 3;
   localparam int DEPTH     = 4;
   localparam int MSG_W     = 22;
   localparam int RX_W      = 19;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [MSG_W-1:0] bus_in = '0;
   logic [2:0]       ctrl = 3'b000;
   logic             inj_valid = 1'b0;
   logic [MSG_W-1:0] inj_msg = '0;
   logic             inj_ready;
   logic [MSG_W-1:0] bus_out;
   logic             bus_out_valid;
   logic             req_valid;
   logic [2:0]       req_dst;
   logic             rx_valid;
   logic [RX_W-1:0]  rx_msg;
   logic [2:0]       count;
   logic             ctrl_err;
   logic             dir_err;
   logic [7:0]       drop_cnt;

   node_port_fifo #(
      .NODE_ID(NODE_ID), .NODE_COUNT(8), .PAYLOAD_W(16), .DEPTH(DEPTH), .DIR(0)
   ) dut (
      .clk(clk), .reset(reset), .bus_in(bus_in), .ctrl(ctrl),
      .inj_valid(inj_valid), .inj_msg(inj_msg), .inj_ready(inj_ready),
      .bus_out(bus_out), .bus_out_valid(bus_out_valid),
      .req_valid(req_valid), .req_dst(req_dst),
      .rx_valid(rx_valid), .rx_msg(rx_msg), .count(count),
      .ctrl_err(ctrl_err), .dir_err(dir_err), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: q is the scoreboard of messages expected on bus_out.
   logic [MSG_W-1:0] q[$];
   int               m_drop = 0;
   bit               m_pend = 1'b0;
   logic [2:0]       m_rdst = '0;
   logic [MSG_W-1:0] m_bo = '0;
   logic [RX_W-1:0]  m_rxm = '0;

   function automatic logic [MSG_W-1:0] mk(input logic [2:0] d, input logic [2:0] s,
                                          input logic [15:0] p);
      return {d, s, p};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input bit e_bov, input bit e_rxv, input bit e_cerr, input bit e_derr);
      check_eq("count",         32'(count),         32'(q.size()));
      check_eq("bus_out_valid", 32'(bus_out_valid), 32'(e_bov));
      check_eq("bus_out",       32'(bus_out),       32'(m_bo));
      check_eq("rx_valid",      32'(rx_valid),      32'(e_rxv));
      check_eq("rx_msg",        32'(rx_msg),        32'(m_rxm));
      check_eq("ctrl_err",      32'(ctrl_err),      32'(e_cerr));
      check_eq("dir_err",       32'(dir_err),       32'(e_derr));
      check_eq("drop_cnt",      32'(drop_cnt),      32'(m_drop));
      check_eq("req_valid",     32'(req_valid),     32'(m_pend));
      check_eq("req_dst",       32'(req_dst),       32'(m_rdst));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      ctrl = 3'b100;
      inj_valid = 1'b1;
      inj_msg = mk(3'd5, 3'd3, 16'h0BAD);
      bus_in = mk(3'd6, 3'd1, 16'h0BAD);
      @(posedge clk); #1;
      reset = 1'b1;
      ctrl = 3'b000;
      inj_valid = 1'b0;
      q.delete();
      m_drop = 0; m_pend = 1'b0; m_rdst = '0; m_bo = '0; m_rxm = '0;
      check_all(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic step(input logic [2:0] c, input logic [MSG_W-1:0] bi,
                       input logic iv, input logic [MSG_W-1:0] im);
      bit e_bov, e_rxv, e_cerr, e_derr, grant, e_rdy;
      e_bov = 1'b0; e_rxv = 1'b0; e_cerr = 1'b0; e_derr = 1'b0; grant = 1'b0;
      ctrl = c; bus_in = bi; inj_valid = iv; inj_msg = im;
      e_rdy = (q.size() <= DEPTH-2);
      check_eq("inj_ready", 32'(inj_ready), 32'(e_rdy));
      case (c)
         3'b100: begin
            if (q.size() > 0) begin
               m_bo = q.pop_front();
               e_bov = 1'b1;
               grant = 1'b1;
            end else begin
               e_cerr = 1'b1;
            end
         end
         3'b010: begin
            if (bi[21:19] == 3'd3) begin
               e_rxv = 1'b1;
               m_rxm = bi[RX_W-1:0];
            end else if (q.size() < DEPTH) begin
               q.push_back(bi);
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end
         3'b001: begin
            m_bo = bi;
            e_bov = 1'b1;
         end
         3'b000: e_cerr = 1'b0;
         default: e_cerr = 1'b1;
      endcase
      if (iv && e_rdy) begin
         if (im[21:19] > 3'd3) q.push_back(im);
         else e_derr = 1'b1;
      end
      if (grant) begin
         m_pend = 1'b0;
      end else if (!m_pend && q.size() > 0) begin
         m_pend = 1'b1;
         m_rdst = q[0][21:19];
      end
      @(posedge clk); #1;
      check_all(e_bov, e_rxv, e_cerr, e_derr);
   endtask

   task automatic idle();
      step(3'b000, '0, 1'b0, '0);
   endtask

   initial begin
      logic [MSG_W-1:0] z;
      z = '0;
      do_reset();
      do_reset();

      // Injection, request, grant
      step(3'b000, z, 1'b1, mk(3'd5, 3'd3, 16'hBEEF));
      check_eq("inj_count1", 32'(count), 32'd1);
      idle();
      check_eq("inj_req_valid", 32'(req_valid), 32'd1);
      check_eq("inj_req_dst", 32'(req_dst), 32'd5);
      step(3'b100, z, 1'b0, z);
      check_eq("tx_bus_out", 32'(bus_out), 32'(mk(3'd5, 3'd3, 16'hBEEF)));
      idle();

      // Local delivery
      step(3'b010, mk(3'd3, 3'd1, 16'h1234), 1'b0, z);
      check_eq("rx_msg_val", 32'(rx_msg), 32'({3'd1, 16'h1234}));
      idle();

      // Forward plus injection in one cycle
      step(3'b000, z, 1'b1, mk(3'd5, 3'd0, 16'h0001));
      step(3'b000, z, 1'b1, mk(3'd4, 3'd0, 16'h0002));
      step(3'b010, mk(3'd6, 3'd2, 16'hAAAA), 1'b1, mk(3'd7, 3'd3, 16'h5555));
      check_eq("dual_push_count", 32'(count), 32'd4);
      idle();
      check_eq("full_inj_ready", 32'(inj_ready), 32'd0);

      // Forwards lost to a full queue, then saturation
      for (int i = 0; i < 3; i++) step(3'b010, mk(3'd6, 3'd1, 16'(i)), 1'b0, z);
      check_eq("drop3", 32'(drop_cnt), 32'd3);
      step(3'b000, z, 1'b1, mk(3'd6, 3'd3, 16'h7777));
      for (int i = 0; i < 260; i++) step(3'b010, mk(3'd0, 3'd1, 16'(i)), 1'b0, z);
      check_eq("drop_sat", 32'(drop_cnt), 32'd255);

      // Drain: order must be 5, 4, 6 (forward), 7 (injection)
      for (int i = 0; i < 4; i++) step(3'b100, z, 1'b0, z);

      // Error pulses
      step(3'b000, z, 1'b1, mk(3'd1, 3'd3, 16'h1111));
      step(3'b000, z, 1'b1, mk(3'd3, 3'd3, 16'h2222));
      step(3'b110, z, 1'b0, z);
      step(3'b111, z, 1'b0, z);
      step(3'b100, z, 1'b0, z);
      check_eq("tx_empty_err", 32'(ctrl_err), 32'd1);

      // Bypass, then bus_out holds
      step(3'b001, mk(3'd2, 3'd0, 16'hCAFE), 1'b0, z);
      idle();

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         logic [2:0] c;
         int r;
         r = $urandom_range(0, 9);
         if (r < 3) c = 3'b100;
         else if (r < 6) c = 3'b010;
         else if (r == 6) c = 3'b001;
         else if (r == 7) c = 3'b000;
         else c = 3'($urandom_range(0, 7));
         step(c, mk(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom)),
              1'($urandom_range(0, 1)),
              mk(3'($urandom_range(0, 7)), 3'd3, 16'($urandom)));
      end

      // Reset mid-operation
      do_reset();
      step(3'b000, z, 1'b1, mk(3'd4, 3'd3, 16'h0A0A));
      step(3'b000, z, 1'b1, mk(3'd5, 3'd3, 16'h0B0B));
      step(3'b010, mk(3'd6, 3'd2, 16'h0C0C), 1'b0, z);
      check_eq("pre_reset_count", 32'(count), 32'd3);
      do_reset();
      check_eq("post_reset_count", 32'(count), 32'd0);
      step(3'b100, z, 1'b0, z);
      check_eq("post_reset_tx_err", 32'(ctrl_err), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
